// File: rtl/pwm_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_cfg_sequencer_if
// Write-only Wishbone link between the PWM configuration sequencer (master)
// and the PWM/timer register block (slave).
//   o_wb_cyc   master -> slave  bus cycle
//   o_wb_stb   master -> slave  strobe
//   o_wb_we    master -> slave  write enable
//   o_wb_adr   master -> slave  16-bit register address
//   o_wb_data  master -> slave  16-bit write data
//   i_wb_ack   slave  -> master acknowledge
// ---------------------------------------------------------------------------
interface pwm_cfg_sequencer_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [15:0] o_wb_adr;
    logic [15:0] o_wb_data;
    logic        i_wb_ack;

    modport master (
        output o_wb_cyc,
        output o_wb_stb,
        output o_wb_we,
        output o_wb_adr,
        output o_wb_data,
        input  i_wb_ack
    );

    modport slave (
        input  o_wb_cyc,
        input  o_wb_stb,
        input  o_wb_we,
        input  o_wb_adr,
        input  o_wb_data,
        output i_wb_ack
    );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_cfg_sequencer
// Wishbone master that programs a PWM/timer block: on i_start it writes
// ctrl (reset value), divisor, period, the first duty value and the enable
// ctrl word, then ramps the duty register towards the end value, one write
// per hold interval. i_abort turns the PWM off with a ctrl=0 write. A write
// that sees no ack for ACK_TIMEOUT strobe cycles is dropped and flags o_err.
// Ports:
//   i_wb_clk, i_wb_rst      clock, asynchronous active-high reset
//   i_start, i_abort        1-cycle request pulses
//   i_ctrl .. i_hold_cyc    sequence configuration, latched on accepted start
//   wb (master modport)     Wishbone write port towards the PWM block
//   o_busy                  sequence in progress
//   o_done, o_aborted       1-cycle completion pulses
//   o_err                   sticky ack-timeout flag
//   o_duty                  last duty value acknowledged by the slave
// ---------------------------------------------------------------------------
module pwm_cfg_sequencer #(
    parameter logic [15:0] BASE_ADR    = 16'h0000,
    parameter int          CTRL_OFS    = 0,
    parameter int          DIV_OFS     = 2,
    parameter int          PER_OFS     = 4,
    parameter int          DUTY_OFS    = 6,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_ctrl,
    input  logic [15:0] i_divisor,
    input  logic [15:0] i_period,
    input  logic [15:0] i_duty_start,
    input  logic [15:0] i_duty_end,
    input  logic [15:0] i_duty_step,
    input  logic [15:0] i_hold_cyc,
    pwm_cfg_sequencer_if.master wb,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_aborted,
    output logic        o_err,
    output logic [15:0] o_duty
);

    localparam logic [15:0] ADR_CTRL = BASE_ADR + 16'(CTRL_OFS);
    localparam logic [15:0] ADR_DIV  = BASE_ADR + 16'(DIV_OFS);
    localparam logic [15:0] ADR_PER  = BASE_ADR + 16'(PER_OFS);
    localparam logic [15:0] ADR_DUTY = BASE_ADR + 16'(DUTY_OFS);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_RST, S_W_DIV, S_W_PER, S_W_DUTY, S_W_CTRL, S_HOLD, S_W_OFF
    } state_t;

    // Next duty step, clamped to the end value on overshoot, on 17-bit
    // carry/borrow, and for a zero step.
    function automatic logic [15:0] next_duty(input logic [15:0] cur,
                                              input logic [15:0] end_v,
                                              input logic [15:0] step,
                                              input logic        up);
        logic [16:0] sum;
        logic [15:0] res;
        if (step == 16'h0000) begin
            sum = 17'h00000;
            res = end_v;
        end else if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (sum[16] || (sum[15:0] > end_v)) ? end_v : sum[15:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            res = (sum[16] || (sum[15:0] < end_v)) ? end_v : sum[15:0];
        end
        return res;
    endfunction

    state_t      state_r, state_s, wr_next_s;
    logic        bus_r, bus_s;
    logic [15:0] adr_r, adr_s, data_r, data_s;
    logic [15:0] wr_adr_s, wr_data_s;
    logic [15:0] to_cnt_r, to_cnt_s, hold_cnt_r, hold_cnt_s;
    logic [15:0] ctrl_r, ctrl_s, div_r, div_s, per_r, per_s;
    logic [15:0] end_r, end_s, step_r, step_s, hold_r, hold_s;
    logic [15:0] duty_wr_r, duty_wr_s, next_duty_s;
    logic        up_r, up_s, first_r, first_s, abort_pend_r, abort_pend_s;
    logic        busy_r, busy_s, done_r, done_s, aborted_r, aborted_s;
    logic        err_r, err_s;
    logic [15:0] duty_r, duty_s;

    assign wb.o_wb_cyc  = bus_r;
    assign wb.o_wb_stb  = bus_r;
    assign wb.o_wb_we   = bus_r;
    assign wb.o_wb_adr  = adr_r;
    assign wb.o_wb_data = data_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_aborted    = aborted_r;
    assign o_err        = err_r;
    assign o_duty       = duty_r;

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_s      = state_r;
        bus_s        = bus_r;
        adr_s        = adr_r;
        data_s       = data_r;
        to_cnt_s     = to_cnt_r;
        hold_cnt_s   = hold_cnt_r;
        ctrl_s       = ctrl_r;
        div_s        = div_r;
        per_s        = per_r;
        end_s        = end_r;
        step_s       = step_r;
        hold_s       = hold_r;
        duty_wr_s    = duty_wr_r;
        up_s         = up_r;
        first_s      = first_r;
        abort_pend_s = abort_pend_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        aborted_s    = 1'b0;
        err_s        = err_r;
        duty_s       = duty_r;
        wr_adr_s     = ADR_CTRL;
        wr_data_s    = 16'h0000;
        wr_next_s    = S_IDLE;
        next_duty_s  = next_duty(duty_wr_r, end_r, step_r, up_r);

        // Address, data and successor of the write owned by each state.
        case (state_r)
            S_W_RST:  begin wr_adr_s = ADR_CTRL; wr_data_s = 16'h0080;  wr_next_s = S_W_DIV;  end
            S_W_DIV:  begin wr_adr_s = ADR_DIV;  wr_data_s = div_r;     wr_next_s = S_W_PER;  end
            S_W_PER:  begin wr_adr_s = ADR_PER;  wr_data_s = per_r;     wr_next_s = S_W_DUTY; end
            S_W_DUTY: begin
                wr_adr_s  = ADR_DUTY;
                wr_data_s = duty_wr_r;
                wr_next_s = first_r ? S_W_CTRL : S_HOLD;
            end
            S_W_CTRL: begin wr_adr_s = ADR_CTRL; wr_data_s = ctrl_r;    wr_next_s = S_HOLD;   end
            S_W_OFF:  begin wr_adr_s = ADR_CTRL; wr_data_s = 16'h0000;  wr_next_s = S_IDLE;   end
            default:  begin wr_adr_s = ADR_CTRL; wr_data_s = 16'h0000;  wr_next_s = S_IDLE;   end
        endcase

        case (state_r)
            S_IDLE: begin
                abort_pend_s = 1'b0;
                // start takes precedence; a lone abort here has no effect
                if (i_start) begin
                    ctrl_s    = i_ctrl;
                    div_s     = i_divisor;
                    per_s     = i_period;
                    end_s     = i_duty_end;
                    step_s    = i_duty_step;
                    hold_s    = (i_hold_cyc == 16'h0000) ? 16'h0001 : i_hold_cyc;
                    duty_wr_s = i_duty_start;
                    up_s      = (i_duty_start <= i_duty_end);
                    first_s   = 1'b1;
                    busy_s    = 1'b1;
                    err_s     = 1'b0;
                    state_s   = S_W_RST;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_abort) begin
                    state_s = S_W_OFF;
                end else if (hold_cnt_r == (hold_r - 16'h0001)) begin
                    if (duty_wr_r == end_r) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = S_IDLE;
                    end else begin
                        // strobe the next duty write straight out of HOLD so the
                        // bus stays idle for exactly the hold interval
                        duty_wr_s = next_duty_s;
                        adr_s     = ADR_DUTY;
                        data_s    = next_duty_s;
                        bus_s     = 1'b1;
                        to_cnt_s  = 16'h0000;
                        state_s   = S_W_DUTY;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + 16'h0001;
                end
            end
            S_W_RST, S_W_DIV, S_W_PER, S_W_DUTY, S_W_CTRL, S_W_OFF: begin
                if (state_r != S_W_OFF) begin
                    abort_pend_s = abort_pend_r | i_abort;
                end else begin
                    abort_pend_s = 1'b0;
                end
                if (!bus_r) begin
                    bus_s    = 1'b1;
                    adr_s    = wr_adr_s;
                    data_s   = wr_data_s;
                    to_cnt_s = 16'h0000;
                end else if (wb.i_wb_ack) begin
                    bus_s      = 1'b0;
                    hold_cnt_s = 16'h0000;
                    if (state_r == S_W_DUTY) begin
                        duty_s  = duty_wr_r;
                        first_s = 1'b0;
                    end else begin
                        duty_s  = duty_r;
                    end
                    if (state_r == S_W_OFF) begin
                        aborted_s = 1'b1;
                        busy_s    = 1'b0;
                        state_s   = S_IDLE;
                    end else if (abort_pend_r || i_abort) begin
                        abort_pend_s = 1'b0;
                        state_s      = S_W_OFF;
                    end else begin
                        state_s = wr_next_s;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    // timeout outranks any pending abort
                    bus_s        = 1'b0;
                    err_s        = 1'b1;
                    busy_s       = 1'b0;
                    abort_pend_s = 1'b0;
                    state_s      = S_IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + 16'h0001;
                end
            end
            default: begin
                bus_s   = 1'b0;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_r      <= S_IDLE;
            bus_r        <= 1'b0;
            adr_r        <= 16'h0000;
            data_r       <= 16'h0000;
            to_cnt_r     <= 16'h0000;
            hold_cnt_r   <= 16'h0000;
            ctrl_r       <= 16'h0000;
            div_r        <= 16'h0000;
            per_r        <= 16'h0000;
            end_r        <= 16'h0000;
            step_r       <= 16'h0000;
            hold_r       <= 16'h0000;
            duty_wr_r    <= 16'h0000;
            up_r         <= 1'b0;
            first_r      <= 1'b0;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            err_r        <= 1'b0;
            duty_r       <= 16'h0000;
        end else begin
            state_r      <= state_s;
            bus_r        <= bus_s;
            adr_r        <= adr_s;
            data_r       <= data_s;
            to_cnt_r     <= to_cnt_s;
            hold_cnt_r   <= hold_cnt_s;
            ctrl_r       <= ctrl_s;
            div_r        <= div_s;
            per_r        <= per_s;
            end_r        <= end_s;
            step_r       <= step_s;
            hold_r       <= hold_s;
            duty_wr_r    <= duty_wr_s;
            up_r         <= up_s;
            first_r      <= first_s;
            abort_pend_r <= abort_pend_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            aborted_r    <= aborted_s;
            err_r        <= err_s;
            duty_r       <= duty_s;
        end
    end

endmodule
